// File: rtl/mul_issue_ctrl_if.sv
// mul_issue_ctrl_if: link between the execute-stage issue controller
// and the iterative multiplier.
// Signals:
//   startM          launch pulse to the multiplier
//   mul_opcode      00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   operand1/2      multiplier operands
//   result_multiply product, valid while done=1
//   done            one-cycle completion pulse
// Modports: master = controller side, slave = multiplier side.
interface mul_issue_ctrl_if;
   logic        startM;
   logic [1:0]  mul_opcode;
   logic [31:0] operand1;
   logic [31:0] operand2;
   logic [31:0] result_multiply;
   logic        done;

   modport master (
      output startM,
      output mul_opcode,
      output operand1,
      output operand2,
      input  result_multiply,
      input  done
   );

   modport slave (
      input  startM,
      input  mul_opcode,
      input  operand1,
      input  operand2,
      output result_multiply,
      output done
   );
endinterface

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: execute-stage issue and stall control for the iterative
// RV32M multiplier, with a one-entry result cache.
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   ex_valid/ex_is_mext/ex_funct3/ex_rs1/ex_rs2/ex_rd/ex_flush
//                      execute-stage instruction
//   mul (master)       multiplier link (startM, opcode, operands, result, done)
//   stall              holds the execute stage (combinational)
//   wb_valid/wb_rd/wb_data  writeback result
//   timeout_err        sticky: multiplier never answered
module mul_issue_ctrl #(
   parameter bit CACHE_EN = 1'b1,
   parameter int TIMEOUT  = 48
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_valid,
   input  logic             ex_is_mext,
   input  logic [2:0]       ex_funct3,
   input  logic [31:0]      ex_rs1,
   input  logic [31:0]      ex_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_flush,
   mul_issue_ctrl_if.master mul,
   output logic             stall,
   output logic             wb_valid,
   output logic [4:0]       wb_rd,
   output logic [31:0]      wb_data,
   output logic             timeout_err
);

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT,
      RESP,
      DRAIN
   } state_t;

   state_t      state;
   state_t      state_nx;

   logic        req;
   logic        hit;
   logic        busy;
   logic        tmo;
   logic [5:0]  tcnt;

   logic        cache_v;
   logic [1:0]  cache_op;
   logic [31:0] cache_a;
   logic [31:0] cache_b;
   logic [31:0] cache_d;

   logic [1:0]  opc_q;
   logic [31:0] op1_q;
   logic [31:0] op2_q;

   assign req = ex_valid & ex_is_mext & ~ex_funct3[2] & ~ex_flush;

   assign hit = CACHE_EN && cache_v
             && (cache_op == ex_funct3[1:0])
             && (cache_a == ex_rs1)
             && (cache_b == ex_rs2);

   assign busy = (state == WAIT) || (state == DRAIN);

   // tcnt counts completed WAIT/DRAIN cycles; this edge makes TIMEOUT.
   assign tmo = (tcnt == 6'(TIMEOUT - 1));

   assign mul.mul_opcode = opc_q;
   assign mul.operand1   = op1_q;
   assign mul.operand2   = op2_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (req) state_nx = hit ? RESP : LAUNCH;
         end
         LAUNCH: begin
            state_nx = ex_flush ? DRAIN : WAIT;
         end
         WAIT: begin
            if (mul.done) state_nx = ex_flush ? IDLE : RESP;
            else if (tmo) state_nx = IDLE;
            else if (ex_flush) state_nx = DRAIN;
         end
         RESP: begin
            state_nx = IDLE;
         end
         DRAIN: begin
            if (mul.done || tmo) state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // stall never looks at done, keeping it off the multiplier's timing path.
   always_comb begin
      mul.startM = 1'b0;
      stall      = 1'b0;
      wb_valid   = 1'b0;
      case (state)
         IDLE: begin
            stall = req;
         end
         LAUNCH: begin
            mul.startM = 1'b1;
            stall      = 1'b1;
         end
         WAIT: begin
            stall = 1'b1;
         end
         RESP: begin
            wb_valid = 1'b1;
         end
         DRAIN: begin
            stall = req;
         end
         default: begin
            stall = 1'b0;
         end
      endcase
   end

   // Operands are captured only on a miss so they stay stable until done.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         opc_q   <= '0;
         op1_q   <= '0;
         op2_q   <= '0;
         wb_rd   <= '0;
         wb_data <= '0;
      end else begin
         if (state == IDLE && req) begin
            wb_rd <= ex_rd;
            if (hit) begin
               wb_data <= cache_d;
            end else begin
               opc_q <= ex_funct3[1:0];
               op1_q <= ex_rs1;
               op2_q <= ex_rs2;
            end
         end
         if (state == WAIT && mul.done) begin
            wb_data <= mul.result_multiply;
         end
      end
   end

   // A drained result is still a valid product, so it refills the cache.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cache_v  <= 1'b0;
         cache_op <= '0;
         cache_a  <= '0;
         cache_b  <= '0;
         cache_d  <= '0;
      end else if (busy && mul.done) begin
         cache_v  <= 1'b1;
         cache_op <= opc_q;
         cache_a  <= op1_q;
         cache_b  <= op2_q;
         cache_d  <= mul.result_multiply;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tcnt        <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state_nx != state &&
             (state_nx == WAIT || state_nx == DRAIN)) begin
            tcnt <= '0;
         end else if (busy) begin
            tcnt <= tcnt + 6'd1;
         end
         if (busy && !mul.done && tmo) begin
            timeout_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: vector table, corner sequences and random ops
// for mul_issue_ctrl, with a 34-cycle multiplier model.
module tb_mul_issue_ctrl;
   localparam int TMO = 48;

   typedef struct {
      logic        mext;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      int          gap;
      int          lat;
      logic [31:0] d;
      int          nst;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_valid = 1'b0;
   logic        ex_is_mext = 1'b0;
   logic [2:0]  ex_funct3 = '0;
   logic [31:0] ex_rs1 = '0;
   logic [31:0] ex_rs2 = '0;
   logic [4:0]  ex_rd = '0;
   logic        ex_flush = 1'b0;
   logic        stall;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        timeout_err;

   int checks = 0;
   int errors = 0;

   logic        never = 1'b0;
   logic        mpend = 1'b0;
   int          mcnt = 0;
   logic [31:0] mres = '0;

   vec_t tbl[13];
   vec_t v;
   vec_t pv;
   logic        cv;
   logic [1:0]  cop;
   logic [31:0] ca, cb, cd;

   mul_issue_ctrl_if mif ();

   mul_issue_ctrl #(.CACHE_EN(1'b1), .TIMEOUT(TMO)) dut (
      .clk(clk),
      .rst(rst),
      .ex_valid(ex_valid),
      .ex_is_mext(ex_is_mext),
      .ex_funct3(ex_funct3),
      .ex_rs1(ex_rs1),
      .ex_rs2(ex_rs2),
      .ex_rd(ex_rd),
      .ex_flush(ex_flush),
      .mul(mif),
      .stall(stall),
      .wb_valid(wb_valid),
      .wb_rd(wb_rd),
      .wb_data(wb_data),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_mul(input logic [1:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] sa, sb, za, zb, p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      za = {32'd0, a};
      zb = {32'd0, b};
      case (op)
         2'd0: p = za * zb;
         2'd1: p = sa * sb;
         2'd2: p = sa * zb;
         default: p = za * zb;
      endcase
      return (op == 2'd0) ? p[31:0] : p[63:32];
   endfunction

   function automatic logic [31:0] pool(input int k);
      case (k)
         0: return 32'd2;
         1: return 32'd3;
         2: return 32'hFFFF_FFFF;
         default: return $urandom();
      endcase
   endfunction

   // Multiplier: samples startM, raises done on the 34th cycle after.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mif.done            <= 1'b0;
         mif.result_multiply <= '0;
         mpend               <= 1'b0;
         mcnt                <= 0;
      end else begin
         mif.done            <= 1'b0;
         mif.result_multiply <= $urandom();
         if (mpend) begin
            if (mcnt == 1) begin
               mif.done            <= 1'b1;
               mif.result_multiply <= mres;
               mpend               <= 1'b0;
            end else begin
               mcnt <= mcnt - 1;
            end
         end
         if (mif.startM && !never) begin
            mpend <= 1'b1;
            mcnt  <= 33;
            mres  <= ref_mul(mif.mul_opcode, mif.operand1, mif.operand2);
         end
      end
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Presents one instruction, holds it while stalled, then lets it go.
   task automatic run_op(input logic mext, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int gap,
                         output int lat, output int nst,
                         output int nstl, output int nwb,
                         output logic [31:0] d, output logic [4:0] r,
                         output logic [1:0] op, output logic stb);
      logic gone, s, trk;
      logic [31:0] o1, o2;
      int post;
      lat = -1; nst = 0; nstl = 0; nwb = 0;
      d = '0; r = '0; op = '0; stb = 1'b1;
      gone = 1'b0; trk = 1'b0; post = 0; o1 = '0; o2 = '0;
      ex_valid = 1'b1; ex_is_mext = mext; ex_funct3 = f3;
      ex_rs1 = a; ex_rs2 = b; ex_rd = rd; ex_flush = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (mif.startM) begin
            nst++;
            op = mif.mul_opcode; o1 = mif.operand1; o2 = mif.operand2;
            trk = 1'b1;
         end else if (trk) begin
            if (mif.mul_opcode != op || mif.operand1 != o1 ||
                mif.operand2 != o2) stb = 1'b0;
            if (mif.done) trk = 1'b0;
         end
         if (stall && !gone) nstl++;
         if (wb_valid) begin
            nwb++;
            if (lat < 0) begin
               lat = c; d = wb_data; r = wb_rd;
            end
         end
         s = stall;
         @(posedge clk);
         #1;
         if (gone) post++;
         else if (!s) begin
            gone = 1'b1;
            ex_valid = 1'b0;
         end
         if (gone && post >= gap) break;
      end
      ex_valid = 1'b0;
   endtask

   task automatic do_op(input vec_t x, input string nm);
      int lat, nst, nstl, nwb;
      logic [31:0] d;
      logic [4:0] r;
      logic [1:0] op;
      logic stb;
      run_op(x.mext, x.f3, x.a, x.b, x.rd, x.gap,
             lat, nst, nstl, nwb, d, r, op, stb);
      chk({nm, ".lat"}, lat, x.lat);
      chk({nm, ".nwb"}, nwb, (x.lat >= 0) ? 1 : 0);
      chk({nm, ".nstall"}, nstl, (x.lat >= 0) ? x.lat : 0);
      chk({nm, ".nstart"}, nst, x.nst);
      chk({nm, ".stable"}, stb, 1);
      if (x.lat >= 0) begin
         chk({nm, ".data"}, d, x.d);
         chk({nm, ".rd"}, r, x.rd);
      end
      if (x.nst > 0) chk({nm, ".opc"}, op, x.f3[1:0]);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int st1, st2, dn, wbc, nwb, te;
      logic [31:0] d;
      logic [4:0] r;
      logic s, stl_ok;
      logic stl[100];

      tbl[0]  = '{1'b1, 3'b000, 32'd7, 32'd6, 5'd5, 0, 36, 32'd42, 1};
      tbl[1]  = '{1'b1, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, 0, 36,
                  32'hFFFFFFFE, 1};
      tbl[2]  = '{1'b1, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, 0, 1,
                  32'hFFFFFFFE, 0};
      tbl[3]  = '{1'b1, 3'b000, 32'd3, 32'd4, 5'd1, 0, 36, 32'd12, 1};
      tbl[4]  = '{1'b1, 3'b011, 32'd3, 32'd4, 5'd2, 0, 36, 32'd0, 1};
      tbl[5]  = '{1'b1, 3'b100, 32'd3, 32'd4, 5'd6, 2, -1, 32'd0, 0};
      tbl[6]  = '{1'b0, 3'b000, 32'd3, 32'd4, 5'd6, 2, -1, 32'd0, 0};
      tbl[7]  = '{1'b1, 3'b001, 32'hFFFFFFFE, 32'd3, 5'd0, 0, 36,
                  32'hFFFFFFFF, 1};
      tbl[8]  = '{1'b1, 3'b010, 32'hFFFFFFFF, 32'd2, 5'd8, 0, 36,
                  32'hFFFFFFFF, 1};
      tbl[9]  = '{1'b1, 3'b010, 32'd2, 32'hFFFFFFFF, 5'd10, 0, 36,
                  32'd1, 1};
      tbl[10] = '{1'b1, 3'b110, 32'd2, 32'hFFFFFFFF, 5'd11, 2, -1,
                  32'd0, 0};
      tbl[11] = '{1'b1, 3'b010, 32'd2, 32'hFFFFFFFF, 5'd12, 0, 1,
                  32'd1, 0};
      tbl[12] = '{1'b1, 3'b000, 32'd2, 32'hFFFFFFFF, 5'd13, 0, 36,
                  32'hFFFFFFFE, 1};
      pv = '{1'b1, 3'b010, 32'd2, 32'hFFFFFFFF, 5'd12, 0, 36, 32'd1, 1};

      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.stall", stall, 0);
      chk("rst.wb_valid", wb_valid, 0);
      chk("rst.timeout_err", timeout_err, 0);
      chk("rst.startM", mif.startM, 0);
      chk("rst.wb_data", wb_data, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 13; i++) do_op(tbl[i], $sformatf("row%0d", i));

      // Flush in the 10th WAIT cycle, new MUL waits through DRAIN.
      st1 = -1; st2 = -1; dn = -1; wbc = -1; nwb = 0;
      d = '0; r = '0; stl_ok = 1'b1;
      ex_valid = 1'b1; ex_is_mext = 1'b1; ex_funct3 = 3'b000;
      ex_rs1 = 32'd11; ex_rs2 = 32'd13; ex_rd = 5'd3; ex_flush = 1'b0;
      for (int c = 0; c < 150; c++) begin
         @(negedge clk);
         if (mif.startM) begin
            if (st1 < 0) st1 = c;
            else if (st2 < 0) st2 = c;
         end
         if (mif.done && dn < 0) dn = c;
         if (wb_valid) begin
            nwb++;
            if (wbc < 0) begin
               wbc = c; d = wb_data; r = wb_rd;
            end
         end
         if (!stall && !wb_valid) stl_ok = 1'b0;
         s = stall;
         @(posedge clk);
         #1;
         ex_flush = (c == 10);
         if (c == 11) begin
            ex_rs1 = 32'd5; ex_rs2 = 32'd9; ex_rd = 5'd4;
         end
         if (!s) begin
            ex_valid = 1'b0;
            break;
         end
      end
      ex_valid = 1'b0; ex_flush = 1'b0;
      chk("flush.start1", st1, 1);
      chk("flush.drain_done", dn, 35);
      chk("flush.start2", st2, 37);
      chk("flush.resp", wbc, 72);
      chk("flush.nwb", nwb, 1);
      chk("flush.data", d, 45);
      chk("flush.rd", r, 4);
      chk("flush.stall_held", stl_ok, 1);

      // Multiplier never answers.
      never = 1'b1; te = -1; nwb = 0;
      for (int c = 0; c < 100; c++) stl[c] = 1'b0;
      ex_valid = 1'b1; ex_is_mext = 1'b1; ex_funct3 = 3'b000;
      ex_rs1 = 32'd2; ex_rs2 = 32'd3; ex_rd = 5'd7;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         stl[c] = stall;
         if (timeout_err && te < 0) te = c;
         if (wb_valid) nwb++;
         @(posedge clk);
         #1;
         if (c == 0) ex_valid = 1'b0;
         if (te >= 0 && c >= te + 2) break;
      end
      chk("tmo.at", te, 50);
      chk("tmo.nwb", nwb, 0);
      chk("tmo.stall_last_wait", stl[49], 1);
      chk("tmo.stall_idle", stl[50], 0);
      chk("tmo.sticky", timeout_err, 1);

      // Reset in the middle of WAIT.
      ex_valid = 1'b1; ex_is_mext = 1'b1; ex_funct3 = 3'b011;
      ex_rs1 = 32'd5; ex_rs2 = 32'd7; ex_rd = 5'd9;
      @(negedge clk);
      chk("rt.accept", stall, 1);
      @(posedge clk);
      #1;
      ex_valid = 1'b0;
      repeat (20) @(posedge clk);
      #3;
      chk("rt.pre_stall", stall, 1);
      chk("rt.pre_opc", mif.mul_opcode, 3);
      chk("rt.pre_op1", mif.operand1, 5);
      rst = 1'b0;
      #1;
      chk("rt.startM", mif.startM, 0);
      chk("rt.stall", stall, 0);
      chk("rt.wb_valid", wb_valid, 0);
      chk("rt.timeout_err", timeout_err, 0);
      chk("rt.opc", mif.mul_opcode, 0);
      chk("rt.op1", mif.operand1, 0);
      chk("rt.op2", mif.operand2, 0);
      chk("rt.wb_rd", wb_rd, 0);
      chk("rt.wb_data", wb_data, 0);
      @(negedge clk);
      rst = 1'b1;
      never = 1'b0;
      @(posedge clk);
      #1;
      do_op(pv, "post_rst");

      // Random ops against a last-result cache model.
      cv = 1'b1; cop = 2'd2; ca = 32'd2; cb = 32'hFFFFFFFF; cd = 32'd1;
      v = pv;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) != 0) begin
            v.f3 = {($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3))};
            v.a = pool(int'($urandom_range(0, 3)));
            v.b = pool(int'($urandom_range(0, 3)));
         end
         v.mext = ($urandom_range(0, 7) != 0);
         v.rd = 5'($urandom_range(0, 31));
         v.gap = int'($urandom_range(0, 2));
         if (!(v.mext && !v.f3[2])) begin
            v.lat = -1; v.d = '0; v.nst = 0;
         end else if (cv && cop == v.f3[1:0] && ca == v.a && cb == v.b) begin
            v.lat = 1; v.d = cd; v.nst = 0;
         end else begin
            v.lat = 36; v.d = ref_mul(v.f3[1:0], v.a, v.b); v.nst = 1;
            cv = 1'b1; cop = v.f3[1:0]; ca = v.a; cb = v.b; cd = v.d;
         end
         do_op(v, $sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mul_issue_ctrl.md
# mul_issue_ctrl

Execute-stage controller that sits directly upstream of the iterative multiplier. It recognises RV32M multiply instructions (MUL, MULH, MULHSU, MULHU), launches the multiplier, stalls the pipeline until the multiplier reports `done`, and presents the 32-bit result to writeback together with the destination register. It also holds a one-entry result cache so that an identical repeated multiply completes without relaunching the multiplier.

## Interface
- CACHE_EN, 1, enables the one-entry result cache (0: every multiply launches).
- TIMEOUT, 48, maximum number of WAIT/DRAIN cycles without `done` before `timeout_err` is raised (range 35..63).

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- ex_valid  in  1  execute-stage instruction valid
- ex_is_mext  in  1  instruction is OP with funct7=0000001
- ex_funct3  in  3  funct3 field; 0xx selects a multiply, 1xx (divide/rem) is not handled
- ex_rs1, ex_rs2  in  32  operand values
- ex_rd  in  5  destination register
- ex_flush  in  1  kills the execute-stage instruction
- startM  out  1  launch pulse to the multiplier
- mul_opcode  out  2  = funct3[1:0] (00 MUL, 01 MULH, 10 MULHSU, 11 MULHU)
- operand1, operand2  out  32  multiplier operands, registered
- result_multiply  in  32  multiplier result, valid while `done`=1
- done  in  1  one-cycle completion pulse from the multiplier
- stall  out  1  hold the execute stage (combinational)
- wb_valid, wb_rd, wb_data  out  1/5/32  writeback result
- timeout_err  out  1  sticky; multiplier failed to respond

## Operation
- req = ex_valid & ex_is_mext & ~ex_funct3[2] & ~ex_flush.
- hit = CACHE_EN & cache_v & (cache_op, cache_a, cache_b) == (funct3[1:0], ex_rs1, ex_rs2).
- States are IDLE, LAUNCH, WAIT, RESP and DRAIN.
- IDLE:
  - On req with ~hit: capture the opcode, operands and rd, then go to LAUNCH.
  - On req with hit: load `wb_data` from the cache and capture rd, then go to RESP.
  - `stall` = req.
- LAUNCH:
  - `startM`=1 for exactly this cycle.
  - `stall`=1.
  - Go to WAIT, or to DRAIN if `ex_flush`.
- WAIT:
  - `stall`=1.
  - On `done`: `wb_data` <= `result_multiply`, and the cache is written (v=1, op, a, b, data); go to RESP.
  - If `ex_flush` arrives without `done`: go to DRAIN.
  - If `ex_flush` and `done` arrive together: write the cache, then go to IDLE with no `wb_valid`.
- RESP:
  - `wb_valid`=1 and `stall`=0; the pipeline advances the instruction this cycle.
  - Always return to IDLE; the instruction still present on the inputs is never re-accepted.
- DRAIN:
  - The multiplier cannot be aborted, so wait for `done`.
  - Write the cache, discard the result, then go to IDLE.
  - `stall` = req (a new multiply must wait); non-multiply instructions are not stalled.
- Divide funct3 (1xx) and non-M instructions are ignored and never stall.
- rd=x0 is processed normally; `wb_rd`=0 and the register file drops the write.
- Timeout:
  - A 6-bit counter clears on entry to WAIT or DRAIN and increments every cycle there.
  - When it reaches TIMEOUT: set `timeout_err` (sticky until reset), return to IDLE, and suppress `wb_valid`.
- Reset: IDLE; `cache_v`=0; `startM`, `stall`, `wb_valid` and `timeout_err` = 0; `mul_opcode`, `operand1`, `operand2`, `wb_rd` and `wb_data` = 0. Reset during WAIT abandons the operation.

## Timing
- `startM` is asserted one cycle after acceptance (the LAUNCH cycle). The multiplier samples it on the edge ending LAUNCH.
- The multiplier raises `done` 34 cycles after that edge. Miss latency from the accept cycle to RESP is therefore 37 cycles, and `stall` is high for 36 of them.
- Cache-hit latency is 1 stall cycle; RESP follows in the next cycle.
- `operand1`, `operand2` and `mul_opcode` stay stable from LAUNCH until `done`.
- `startM` is never asserted while in WAIT or DRAIN.
- Back-to-back multiplies: the second is accepted in the IDLE cycle following RESP.
- `stall` is purely combinational from state and inputs and must not depend on `done`.

## Test plan
- MUL, rs1=7, rs2=6, rd=5, with a bench multiplier model of 34-cycle latency:
  - one `startM` pulse with `mul_opcode`=00;
  - `stall` high for 36 cycles;
  - then `wb_valid`=1, `wb_rd`=5, `wb_data`=42 for exactly one cycle.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF followed immediately by the identical instruction:
  - first: `wb_data`=0xFFFFFFFE after 37 cycles;
  - second: cache hit, no `startM`, `wb_data`=0xFFFFFFFE two cycles after its accept.
- MUL 3×4, then MULHU 3×4:
  - the opcode mismatch is a cache miss, so the multiplier is relaunched with `mul_opcode`=11;
  - `wb_data`=0.
- `ex_flush` in the 10th WAIT cycle, with a new MUL presented during DRAIN:
  - no `wb_valid` for the flushed op;
  - `stall` stays high until `done`;
  - the new MUL launches after returning to IDLE.
- `ex_funct3`=100 with `ex_is_mext`=1: `stall`=0, no `startM`, no `wb_valid`.
- Bench model never asserts `done`:
  - `timeout_err`=1 after 48 WAIT cycles;
  - controller returns to IDLE with no `wb_valid`;
  - assert `rst`=0 mid-WAIT and check that all outputs reach their reset values immediately.
